// File: rtl/dmem_wbuf_bridge_pkg.sv
// Shared types for the MEM-stage write-buffer bridge.
//   wbuf_state_e   : load FSM state codes (3-bit)
//   load_stalls()  : states in which an outstanding load holds the pipeline
package dmem_wbuf_bridge_pkg;

  typedef enum logic [2:0] {
    WBUF_ST_IDLE  = 3'd0,
    WBUF_ST_DRAIN = 3'd1,
    WBUF_ST_LREQ  = 3'd2,
    WBUF_ST_LWAIT = 3'd3,
    WBUF_ST_DONE  = 3'd4
  } wbuf_state_e;

  function automatic logic load_stalls(input wbuf_state_e st);
    return (st == WBUF_ST_DRAIN) || (st == WBUF_ST_LREQ) || (st == WBUF_ST_LWAIT);
  endfunction

endpackage

// File: rtl/dmem_wbuf_bridge_wbuf_fifo.sv
// wbuf_fifo: in-order store buffer for the data-memory bridge.
//   clk, rst (async, active-low)
//   push, wdata : enqueue an entry (ignored when full)
//   pop         : dequeue the head entry (ignored when empty)
//   full, empty : occupancy flags
//   head        : current head entry (meaningless while empty)
module wbuf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[head_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + 1'b1;
      if (do_pop)  head_q <= head_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail_q] <= wdata;
  end

endmodule

// File: rtl/dmem_wbuf_bridge.sv
// dmem_wbuf_bridge: MEM-stage data port onto a handshaked bus.
// Stores are posted into a write buffer and drained in order; loads stall the
// pipeline until the buffer is empty and the read data has returned.
//   clk, rst (async, active-low)
//   ram_ce_i/we_i/addr_i/data_i/sel_i : MEM-stage access
//   stall_i      : MEM stage held by ctrl; a store is not consumed while set
//   ram_data_o   : load data, non-zero only in DONE
//   stallreq_o   : stall request to ctrl
//   bus_*        : request channel (req/gnt) and read return (rvalid/rdata)
//   dbg_state_o  : load FSM state, for observation
//
// Bus handshake: bus_req_o is a valid; bus_gnt_i is its ready. A transfer
// happens on every rising edge where both are 1. While bus_req_o is 1 and
// bus_gnt_i is 0 the request fields are held unchanged. A read's data is
// accepted only when bus_rvalid_i is 1 in LWAIT; rvalid at any other time is
// dropped.
module dmem_wbuf_bridge
  import dmem_wbuf_bridge_pkg::*;
#(
  parameter  int ADDR_W     = 32,
  parameter  int DATA_W     = 32,
  parameter  int WBUF_DEPTH = 4,
  localparam int SEL_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_ce_i,
  input  logic              ram_we_i,
  input  logic [ADDR_W-1:0] ram_addr_i,
  input  logic [DATA_W-1:0] ram_data_i,
  input  logic [SEL_W-1:0]  ram_sel_i,
  input  logic              stall_i,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              stallreq_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [SEL_W-1:0]  bus_sel_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output wbuf_state_e       dbg_state_o
);

  localparam int ENTRY_W = ADDR_W + DATA_W + SEL_W;

  wbuf_state_e       state_q;
  logic [DATA_W-1:0] rdata_q;

  logic               is_load;
  logic               is_store;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic               drain_active;
  logic [ENTRY_W-1:0] head;

  assign is_load  = ram_ce_i && !ram_we_i;
  assign is_store = ram_ce_i && ram_we_i;
  // Fullness is judged at the edge: a pop in the same cycle does not open a slot.
  assign push     = is_store && !stall_i && !full;

  // The buffer drains only while no load owns the bus.
  assign drain_active = !empty && ((state_q == WBUF_ST_IDLE) || (state_q == WBUF_ST_DRAIN));
  assign pop          = drain_active && bus_gnt_i;

  wbuf_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({ram_addr_i, ram_data_i, ram_sel_i}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_comb begin
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    bus_sel_o   = '0;
    if (drain_active) begin
      bus_req_o                           = 1'b1;
      bus_we_o                            = 1'b1;
      {bus_addr_o, bus_wdata_o, bus_sel_o} = head;
    end else if (state_q == WBUF_ST_LREQ) begin
      // The load stays presented on ram_*_i while stalled, so its fields are stable.
      bus_req_o  = 1'b1;
      bus_addr_o = ram_addr_i;
      bus_sel_o  = ram_sel_i;
    end
  end

  // A load newly seen in IDLE must stall at once or the pipeline would move
  // past it. rst gates the request so every output is 0 while reset is held.
  assign stallreq_o = rst && ((is_store && full) ||
                              ((state_q == WBUF_ST_IDLE) && is_load) ||
                              load_stalls(state_q));

  assign ram_data_o  = (state_q == WBUF_ST_DONE) ? rdata_q : '0;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WBUF_ST_IDLE;
      rdata_q <= '0;
    end else begin
      case (state_q)
        WBUF_ST_IDLE: begin
          if (is_load) state_q <= empty ? WBUF_ST_LREQ : WBUF_ST_DRAIN;
        end
        WBUF_ST_DRAIN: begin
          if (empty) state_q <= WBUF_ST_LREQ;
        end
        WBUF_ST_LREQ: begin
          if (bus_gnt_i) state_q <= WBUF_ST_LWAIT;
        end
        WBUF_ST_LWAIT: begin
          if (bus_rvalid_i) begin
            rdata_q <= bus_rdata_i;
            state_q <= WBUF_ST_DONE;
          end
        end
        WBUF_ST_DONE: begin
          // While MEM is held the same load is re-presented; it must not reissue.
          if (!stall_i) state_q <= WBUF_ST_IDLE;
        end
        default: state_q <= WBUF_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_wbuf_bridge.sv
module tb_dmem_wbuf_bridge;
  import dmem_wbuf_bridge_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int EW = AW + DW + SW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ram_ce_i, ram_we_i, stall_i;
  logic [AW-1:0] ram_addr_i;
  logic [DW-1:0] ram_data_i;
  logic [SW-1:0] ram_sel_i;
  logic [DW-1:0] ram_data_o;
  logic          stallreq_o;
  logic          bus_req_o, bus_we_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic [SW-1:0] bus_sel_o;
  logic          bus_gnt_i, bus_rvalid_i;
  logic [DW-1:0] bus_rdata_i;
  wbuf_state_e   dbg_state_o;

  dmem_wbuf_bridge #(.ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .ram_ce_i     (ram_ce_i),
    .ram_we_i     (ram_we_i),
    .ram_addr_i   (ram_addr_i),
    .ram_data_i   (ram_data_i),
    .ram_sel_i    (ram_sel_i),
    .stall_i      (stall_i),
    .ram_data_o   (ram_data_o),
    .stallreq_o   (stallreq_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_sel_o    (bus_sel_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int            checks = 0;
  int            errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] exp_rd_addr = '0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor: every granted write must be the oldest expected store.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst && bus_req_o && bus_gnt_i) begin
      if (bus_we_o) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h expected no write", bus_addr_o);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", bus_addr_o, e[EW-1 -: AW]);
          check("wr_data", bus_wdata_o, e[SW +: DW]);
          check("wr_sel", bus_sel_o, e[SW-1:0]);
        end
      end else begin
        rd_cnt++;
        check("rd_addr", bus_addr_o, exp_rd_addr);
        check("rd_after_stores", exp_q.size(), 0);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic          ce, we, stl, gnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
    logic          exp_stall, exp_req;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic ce, input logic we, input logic stl, input logic gnt,
                              input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input logic [SW-1:0] sel, input logic exp_stall, input logic exp_req);
    vec_t v;
    v.ce = ce; v.we = we; v.stl = stl; v.gnt = gnt;
    v.addr = addr; v.data = data; v.sel = sel;
    v.exp_stall = exp_stall; v.exp_req = exp_req;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    ram_ce_i = 1'b0; ram_we_i = 1'b0; stall_i = 1'b0;
    ram_addr_i = '0; ram_data_i = '0; ram_sel_i = '0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents a load and plays the bus: writes granted at once, the read granted
  // after gdel request cycles, rvalid rdel cycles after the earliest legal slot.
  // Returns at the negedge of the first non-stalled cycle.
  task automatic run_load(input logic [AW-1:0] addr, input int gdel, input int rdel,
                          input logic [DW-1:0] rdat, input logic hold, output int stalls);
    int lreq_cnt;
    int wait_cnt;
    bit granted;
    bit done;
    lreq_cnt = 0; wait_cnt = 0; granted = 0; done = 0; stalls = 0;
    exp_rd_addr = addr;
    ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_addr_i = addr; ram_sel_i = '1;
    ram_data_i = '0; stall_i = hold;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
      #1;
      if (bus_req_o && bus_we_o) bus_gnt_i = 1'b1;
      else if (bus_req_o) begin
        if (lreq_cnt == gdel) bus_gnt_i = 1'b1;
        lreq_cnt++;
      end
      if (granted) begin
        if (wait_cnt == rdel) begin
          bus_rvalid_i = 1'b1;
          bus_rdata_i  = rdat;
        end else begin
          bus_rdata_i = $urandom;
        end
        wait_cnt++;
      end
      @(negedge clk);
      if (!stallreq_o) done = 1;
      else begin
        stalls++;
        if (bus_req_o && !bus_we_o && bus_gnt_i) granted = 1;
        next_cycle();
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: got no completion expected completion within 64 cycles");
    end
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
  endtask

  task automatic post_store(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] sel);
    ram_ce_i = 1'b1; ram_we_i = 1'b1; stall_i = 1'b0; bus_gnt_i = 1'b0;
    ram_addr_i = addr; ram_data_i = data; ram_sel_i = sel;
    @(negedge clk);
    check("post_no_stall", stallreq_o, 1'b0);
    exp_q.push_back({addr, data, sel});
    next_cycle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int            stalls;
    int            rd_before;
    int            n;
    int            req_seen;
    logic [DW-1:0] rdat;
    logic [DW-1:0] e_data;

    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_stallreq", stallreq_o, 1'b0);
    check("rst_bus_req", bus_req_o, 1'b0);
    check("rst_ram_data", ram_data_o, '0);
    check("rst_state", dbg_state_o, WBUF_ST_IDLE);
    next_cycle();

    // Table: fill to full with gnt=0, stall on the 5th store, full-with-pop
    // still stalls, drain, single store with immediate drain, stall_i blocks push.
    e_data = $urandom;
    vecs[0]  = mk(1, 1, 0, 0, 32'h100, 32'hDEAD_BEEF, 4'hF, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 32'h104, $urandom, 4'h3, 0, 1);
    vecs[2]  = mk(1, 1, 0, 0, 32'h108, $urandom, 4'hC, 0, 1);
    vecs[3]  = mk(1, 1, 0, 0, 32'h10C, $urandom, 4'h1, 0, 1);
    vecs[4]  = mk(1, 1, 0, 0, 32'h110, e_data, 4'hF, 1, 1);
    vecs[5]  = mk(1, 1, 0, 0, 32'h110, e_data, 4'hF, 1, 1);
    vecs[6]  = mk(1, 1, 0, 1, 32'h110, e_data, 4'hF, 1, 1);
    vecs[7]  = mk(1, 1, 0, 0, 32'h110, e_data, 4'hF, 0, 1);
    vecs[8]  = mk(0, 0, 0, 1, 32'h0, 32'h0, 4'h0, 0, 1);
    vecs[9]  = mk(0, 0, 0, 1, 32'h0, 32'h0, 4'h0, 0, 1);
    vecs[10] = mk(1, 1, 0, 1, 32'h114, $urandom, 4'h6, 0, 1);
    vecs[11] = mk(0, 0, 0, 1, 32'h0, 32'h0, 4'h0, 0, 1);
    vecs[12] = mk(0, 0, 0, 1, 32'h0, 32'h0, 4'h0, 0, 1);
    vecs[13] = mk(0, 0, 0, 1, 32'h0, 32'h0, 4'h0, 0, 0);
    vecs[14] = mk(1, 1, 0, 1, 32'h200, $urandom, 4'hF, 0, 0);
    vecs[15] = mk(0, 0, 0, 1, 32'h0, 32'h0, 4'h0, 0, 1);
    vecs[16] = mk(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0);
    vecs[17] = mk(1, 1, 1, 0, 32'h300, $urandom, 4'hF, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0);

    for (int i = 0; i < 19; i++) begin
      ram_ce_i = vecs[i].ce; ram_we_i = vecs[i].we; stall_i = vecs[i].stl;
      bus_gnt_i = vecs[i].gnt; ram_addr_i = vecs[i].addr;
      ram_data_i = vecs[i].data; ram_sel_i = vecs[i].sel;
      @(negedge clk);
      check($sformatf("vec%0d_stallreq", i), stallreq_o, vecs[i].exp_stall);
      check($sformatf("vec%0d_bus_req", i), bus_req_o, vecs[i].exp_req);
      if (vecs[i].ce && vecs[i].we && !vecs[i].stl && !vecs[i].exp_stall)
        exp_q.push_back({vecs[i].addr, vecs[i].data, vecs[i].sel});
      next_cycle();
    end
    idle_inputs();
    check("table_all_written", exp_q.size(), 0);
    check("table_write_count", wr_cnt, 7);

    // Zero-wait load, empty buffer: three stalled cycles.
    rdat = $urandom;
    rd_before = rd_cnt;
    run_load(32'h180, 0, 0, rdat, 1'b0, stalls);
    check("zw_stalls", stalls, 3);
    check("zw_data", ram_data_o, rdat);
    check("zw_reads", rd_cnt - rd_before, 1);
    next_cycle();
    idle_inputs();

    // Two buffered stores, then a load: stores drain before the read.
    post_store(32'h100, 32'h1111_2222, 4'hF);
    post_store(32'h104, 32'h3333_4444, 4'h3);
    rdat = $urandom;
    rd_before = rd_cnt;
    run_load(32'h100, 0, 0, rdat, 1'b0, stalls);
    check("drain_stalls", stalls, 5);
    check("drain_data", ram_data_o, rdat);
    check("drain_empty", exp_q.size(), 0);
    check("drain_reads", rd_cnt - rd_before, 1);
    next_cycle();
    idle_inputs();

    // Grant delayed three cycles, rvalid two cycles after grant: seven stalls, one DONE cycle.
    rdat = $urandom;
    rd_before = rd_cnt;
    run_load(32'h240, 3, 1, rdat, 1'b0, stalls);
    check("slow_stalls", stalls, 7);
    check("slow_data", ram_data_o, rdat);
    check("slow_state_done", dbg_state_o, WBUF_ST_DONE);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("slow_back_idle", dbg_state_o, WBUF_ST_IDLE);
    check("slow_data_cleared", ram_data_o, '0);
    check("slow_reads", rd_cnt - rd_before, 1);
    next_cycle();

    // DONE held by stall_i for two more cycles: no reissue, data stable.
    rdat = $urandom;
    rd_before = rd_cnt;
    run_load(32'h2C0, 1, 0, rdat, 1'b1, stalls);
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("hold%0d_state", k), dbg_state_o, WBUF_ST_DONE);
      check($sformatf("hold%0d_stallreq", k), stallreq_o, 1'b0);
      check($sformatf("hold%0d_data", k), ram_data_o, rdat);
      check($sformatf("hold%0d_bus_req", k), bus_req_o, 1'b0);
    end
    next_cycle();
    stall_i = 1'b0;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("hold_release_idle", dbg_state_o, WBUF_ST_IDLE);
    check("hold_reads", rd_cnt - rd_before, 1);
    next_cycle();

    // Reset asserted during LWAIT with two stores sitting in the buffer.
    exp_rd_addr = 32'h400;
    ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_addr_i = 32'h400; ram_sel_i = 4'hF;
    n = 0;
    while (dbg_state_o != WBUF_ST_LWAIT && n < 10) begin
      bus_gnt_i = 1'b0;
      #1;
      bus_gnt_i = bus_req_o && !bus_we_o;
      next_cycle();
      n++;
    end
    bus_gnt_i = 1'b0;
    check("rst6_reach_lwait", dbg_state_o, WBUF_ST_LWAIT);
    ram_we_i = 1'b1; ram_addr_i = 32'h500; ram_data_i = $urandom;
    next_cycle();
    ram_addr_i = 32'h504; ram_data_i = $urandom;
    next_cycle();
    ram_ce_i = 1'b0; ram_we_i = 1'b0;
    #1;
    check("rst6_lwait_no_drain", bus_req_o, 1'b0);
    rst = 1'b0;
    #1;
    check("rst6_stallreq", stallreq_o, 1'b0);
    check("rst6_bus_req", bus_req_o, 1'b0);
    check("rst6_bus_we", bus_we_o, 1'b0);
    check("rst6_bus_addr", bus_addr_o, '0);
    check("rst6_bus_wdata", bus_wdata_o, '0);
    check("rst6_bus_sel", bus_sel_o, '0);
    check("rst6_ram_data", ram_data_o, '0);
    check("rst6_state", dbg_state_o, WBUF_ST_IDLE);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle_inputs();
    bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = $urandom;
    req_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus_req_o) req_seen++;
      next_cycle();
    end
    check("rst6_no_bus_activity", req_seen, 0);
    check("rst6_idle_after", dbg_state_o, WBUF_ST_IDLE);
    check("rst6_data_zero", ram_data_o, '0);
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
